// File: rtl/ucaspian_dendrite_acc.sv
// ----------------------------------------------------------------------------
// ucaspian_dendrite_acc
//
// Double-buffered dendrite accumulator sitting between the synapse stage and
// the neuron stage. Synapse fires add signed charge into the incoming bank;
// next_step swaps banks and flushes the outgoing bank to the neuron stage,
// visiting only activity-flagged groups and skipping zero entries. The flush
// writes zero behind itself, so a bank is all-zero when it becomes incoming.
//
// Optional build macro: DENDRITE_SAT_EN
//   defined   -> accumulation saturates to the signed ACC_W range
//   undefined -> accumulation wraps modulo 2^ACC_W
//
// Ports:
//   clk           clock
//   reset         synchronous active-high reset (starts a clear sweep)
//   i_enable      0 forces o_syn_rdy low and blocks new o_neu_vld
//   i_clear_act   pulse: zero both banks and activity vectors
//   o_clear_done  1-cycle pulse when a clear sweep finishes
//   i_next_step   pulse: swap banks and start flush (only when o_step_done)
//   o_step_done   flush complete and accumulate pipeline empty
//   i_syn_addr    target neuron of a synapse fire
//   i_syn_charge  signed charge of a synapse fire
//   i_syn_vld     synapse fire valid
//   o_syn_rdy     synapse fire ready
//   o_neu_addr    flushed neuron address
//   o_neu_charge  flushed signed accumulated charge
//   o_neu_vld     flush output valid (held stable until i_neu_rdy)
//   i_neu_rdy     flush output ready
// ----------------------------------------------------------------------------
module ucaspian_dendrite_acc #(
    parameter int ADDR_W = 8,
    parameter int IN_W   = 9,
    parameter int ACC_W  = 16,
    parameter int GRP_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_enable,
    input  logic                     i_clear_act,
    output logic                     o_clear_done,
    input  logic                     i_next_step,
    output logic                     o_step_done,
    input  logic [ADDR_W-1:0]        i_syn_addr,
    input  logic signed [IN_W-1:0]   i_syn_charge,
    input  logic                     i_syn_vld,
    output logic                     o_syn_rdy,
    output logic [ADDR_W-1:0]        o_neu_addr,
    output logic signed [ACC_W-1:0]  o_neu_charge,
    output logic                     o_neu_vld,
    input  logic                     i_neu_rdy
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NGRP_W = ADDR_W - GRP_W;
    localparam int NGRP   = 1 << NGRP_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    // Accumulate: sign-extend the charge and add, saturating or wrapping.
    function automatic logic signed [ACC_W-1:0] acc_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [IN_W-1:0]  b
    );
`ifdef DENDRITE_SAT_EN
        logic signed [ACC_W:0] s;
        s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
        if (s[ACC_W] != s[ACC_W-1])
            acc_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            acc_add = s[ACC_W-1:0];
`else
        acc_add = a + ACC_W'(b);
`endif
    endfunction

    // Both banks live in one array indexed {bank, addr}.
    logic signed [ACC_W-1:0]  r_mem [0:2*DEPTH-1];

    // Clear sweep and bank control
    logic                     r_sweep;
    logic [ADDR_W-1:0]        r_sweep_addr;
    logic                     r_clear_done;
    logic                     r_bank_sel;
    logic [1:0][NGRP-1:0]     r_act;

    // Accumulate pipeline
    logic                     r_vld_p1;
    logic [ADDR_W-1:0]        r_addr_p1;
    logic signed [IN_W-1:0]   r_chg_p1;
    logic                     r_bank_p1;
    logic signed [ACC_W-1:0]  r_rd_p1;
    logic                     r_vld_p2;
    logic [ADDR_W-1:0]        r_addr_p2;
    logic                     r_bank_p2;
    logic signed [ACC_W-1:0]  r_sum_p2;

    // Flush
    state_t                   r_state;
    state_t                   w_state_next;
    logic [ADDR_W-1:0]        r_idx;
    logic signed [ACC_W-1:0]  r_fl_rd;
    logic                     r_neu_vld;
    logic [ADDR_W-1:0]        r_neu_addr;
    logic signed [ACC_W-1:0]  r_neu_charge;

    logic                     w_syn_fire;
    logic                     w_sweep_last;
    logic                     w_pipe_empty;
    logic                     w_step_acc;
    logic                     w_fwd;
    logic signed [ACC_W-1:0]  w_operand;
    logic signed [ACC_W-1:0]  w_sum_p1;
    logic                     w_out_bank;
    logic [NGRP-1:0]          w_out_act;
    logic                     w_grp_found;
    logic [NGRP_W-1:0]        w_grp;
    logic                     w_out_busy;
    logic                     w_idx_grp_end;
    logic                     w_fl_nonzero;
    logic                     w_send_done;
    logic                     w_flush_wr;

    assign o_syn_rdy     = i_enable && !r_sweep && !i_next_step;
    assign w_syn_fire    = i_syn_vld && o_syn_rdy;
    assign w_sweep_last  = r_sweep && (r_sweep_addr == '1);
    assign w_pipe_empty  = !r_vld_p1 && !r_vld_p2;
    assign o_step_done   = (r_state == S_DONE) && w_pipe_empty;
    assign w_step_acc    = i_next_step && o_step_done;
    assign o_clear_done  = r_clear_done;
    assign o_neu_vld     = r_neu_vld;
    assign o_neu_addr    = r_neu_addr;
    assign o_neu_charge  = r_neu_charge;

    // S2 has just written this address/bank, so the RAM word captured for S1
    // is stale; take the freshly computed sum instead.
    assign w_fwd     = r_vld_p2 && (r_addr_p2 == r_addr_p1) && (r_bank_p2 == r_bank_p1);
    assign w_operand = w_fwd ? r_sum_p2 : r_rd_p1;
    assign w_sum_p1  = acc_add(w_operand, r_chg_p1);

    assign w_out_bank    = ~r_bank_sel;
    assign w_out_act     = r_act[w_out_bank];
    // A fire still in flight for the outgoing bank may yet set an activity bit.
    assign w_out_busy    = r_vld_p1 && (r_bank_p1 == w_out_bank);
    assign w_idx_grp_end = (r_idx[GRP_W-1:0] == '1);
    assign w_fl_nonzero  = (r_fl_rd != '0);
    assign w_send_done   = !w_fl_nonzero || (r_neu_vld && i_neu_rdy);
    assign w_flush_wr    = (r_state == S_SEND) && w_send_done;

    // Lowest set activity bit of the outgoing bank.
    always_comb begin
        w_grp_found = 1'b0;
        w_grp       = '0;
        for (int g = NGRP - 1; g >= 0; g--) begin
            if (w_out_act[g]) begin
                w_grp_found = 1'b1;
                w_grp       = NGRP_W'(g);
            end
        end
    end

    // Flush FSM next-state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: w_state_next = S_IDLE;
            S_SCAN: begin
                if (!w_out_busy)
                    w_state_next = w_grp_found ? S_READ : S_DONE;
            end
            S_READ: begin
                if (i_enable)
                    w_state_next = S_SEND;
            end
            S_SEND: begin
                if (w_send_done)
                    w_state_next = w_idx_grp_end ? S_SCAN : S_READ;
            end
            S_DONE: begin
                if (w_step_acc)
                    w_state_next = S_SCAN;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (r_sweep)
            w_state_next = w_sweep_last ? S_DONE : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset || i_clear_act)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Clear sweep, bank select and activity vectors
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sweep      <= 1'b1;
            r_sweep_addr <= '0;
            r_clear_done <= 1'b0;
            r_bank_sel   <= 1'b0;
            r_act        <= '0;
        end else begin
            r_clear_done <= 1'b0;
            if (i_clear_act) begin
                r_sweep      <= 1'b1;
                r_sweep_addr <= '0;
                r_act        <= '0;
            end else begin
                if (r_sweep) begin
                    r_sweep_addr <= r_sweep_addr + ADDR_W'(1);
                    if (w_sweep_last) begin
                        r_sweep      <= 1'b0;
                        r_clear_done <= 1'b1;
                    end
                end
                if (r_vld_p1)
                    r_act[r_bank_p1][r_addr_p1[ADDR_W-1:GRP_W]] <= 1'b1;
                if (w_flush_wr && w_idx_grp_end)
                    r_act[w_out_bank][r_idx[ADDR_W-1:GRP_W]] <= 1'b0;
                if (w_step_acc) begin
                    r_bank_sel        <= ~r_bank_sel;
                    r_act[w_out_bank] <= '0;
                end
            end
        end
    end

    // ---- stage p0 -> p1: accept fire, read RAM ----
    // ---- stage p1 -> p2: add, write back, hold result for forwarding ----
    always_ff @(posedge clk) begin
        if (reset || i_clear_act) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p1 <= w_syn_fire;
            r_vld_p2 <= r_vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        r_addr_p1 <= i_syn_addr;
        r_chg_p1  <= i_syn_charge;
        r_bank_p1 <= r_bank_sel;
        r_rd_p1   <= r_mem[{r_bank_sel, i_syn_addr}];
        r_addr_p2 <= r_addr_p1;
        r_bank_p2 <= r_bank_p1;
        r_sum_p2  <= w_sum_p1;
        r_fl_rd   <= r_mem[{w_out_bank, r_idx}];
        if (r_state == S_SCAN && !w_out_busy && w_grp_found)
            r_idx <= {w_grp, {GRP_W{1'b0}}};
        else if (w_flush_wr && !w_idx_grp_end)
            r_idx <= r_idx + ADDR_W'(1);
    end

    // The sweep writes last so it wins over any write in the cycle it starts.
    always_ff @(posedge clk) begin
        if (r_vld_p1)
            r_mem[{r_bank_p1, r_addr_p1}] <= w_sum_p1;
        if (w_flush_wr)
            r_mem[{w_out_bank, r_idx}] <= '0;
        if (r_sweep) begin
            r_mem[{1'b0, r_sweep_addr}] <= '0;
            r_mem[{1'b1, r_sweep_addr}] <= '0;
        end
    end

    // ---- flush output register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_neu_vld    <= 1'b0;
            r_neu_addr   <= '0;
            r_neu_charge <= '0;
        end else if (i_clear_act) begin
            r_neu_vld <= 1'b0;
        end else if (r_state == S_SEND) begin
            if (r_neu_vld) begin
                if (i_neu_rdy)
                    r_neu_vld <= 1'b0;
            end else if (w_fl_nonzero && i_enable) begin
                r_neu_vld    <= 1'b1;
                r_neu_addr   <= r_idx;
                r_neu_charge <= r_fl_rd;
            end
        end
    end

endmodule
